fir_mac_scheduler: RTL and testbench

- Time-multiplexed FIR controller: one signed multiplier-accumulator is shared across all TAPS, and the block steps it through one tap per cycle.
- Owns the sample delay line and a double-buffered coefficient bank (shadow bank for writes, active bank for compute).
- Input samples arrive on a valid/ready stream; filtered results leave on a valid/ready stream.
- Sits between the sample source and the downstream consumer, and replaces the fully parallel filter where area matters more than throughput.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_mac_scheduler_if.sv | 34 +++
 rtl/fir_mac_unit.sv | 35 +++
 rtl/fir_mac_scheduler.sv | 119 +++++++++++
 tb/tb_fir_mac_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR scheduler.
// Optional build macro: FIR_SCHED_SAT_EN selects saturating output conversion; otherwise the result wraps.
// Pure declarations; no timing or flow-control behaviour of its own.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Full-precision accumulator width: product width plus growth for TAPS additions.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Accumulator to output conversion. The caller keeps the low out_w bits of the result.
  function automatic logic signed [63:0] conv(input logic signed [63:0] acc, input int out_w);
`ifdef FIR_SCHED_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    // Sign-extend from bit out_w-1 so the value matches a two's-complement wrap.
    return (acc <<< (64 - out_w)) >>> (64 - out_w);
`endif
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample-in / result-out streams and coefficient write port of the FIR scheduler.
// Latency: none; pure wiring bundle.
// Backpressure: s_ready stalls the source, m_ready stalls the result register.
interface fir_mac_scheduler_if #(
  parameter int TAPS   = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [OUT_W-1:0]  m_data;
  logic                     busy;

  // Sample source / result consumer side.
  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
    input  s_ready, m_valid, m_data, busy
  );

  // Filter side.
  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_wdata, m_ready,
    output s_ready, m_valid, m_data, busy
  );
endinterface

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate shared by all filter taps.
// Latency: one cycle per product; acc_nxt exposes the sum that the next edge will store.
// Backpressure: none; clr and en are driven by the scheduler.
module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  acc_nxt
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod;

  assign prod    = PW'(a) * PW'(b);
  assign acc_nxt = acc + ACC_W'(prod);

  // Accumulator: clear starts a new output, enable adds one tap product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end
endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one MAC stepped over TAPS taps; build macro FIR_SCHED_SAT_EN saturates the output.
// Latency: m_valid rises TAPS cycles after the sample accept; one sample per TAPS+2 cycles at best.
// Backpressure: s_ready only in IDLE; the result is held in OUT until m_ready.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  fir_mac_scheduler_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  state_t                   state;
  logic [AW-1:0]            idx;
  logic signed [DATA_W-1:0] dly    [TAPS];
  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     accept;
  logic                     last_tap;
  logic                     wr_ok;

  assign bus.s_ready = (state == IDLE) && !rst;
  assign bus.busy    = (state != IDLE);
  assign accept      = bus.s_valid && bus.s_ready;
  assign last_tap    = (idx == AW'(TAPS - 1));

  // Addresses past the last tap are dropped; with a power-of-two TAPS every address is valid.
  if ((1 << AW) == TAPS) begin : g_addr_full
    assign wr_ok = bus.coef_we;
  end else begin : g_addr_part
    assign wr_ok = bus.coef_we && (bus.coef_addr < AW'(TAPS));
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == MAC),
    .a       (dly[idx]),
    .b       (active[idx]),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  // Control FSM: accept a sample, walk the taps, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (last_tap) begin
            // acc_nxt already contains the final tap product.
            bus.m_data  <= OUT_W'(conv(64'(acc_nxt), OUT_W));
            bus.m_valid <= 1'b1;
            state       <= OUT;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample delay line: shifts once per accepted sample, newest at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) dly[k] <= '0;
    end else if (accept) begin
      dly[0] <= bus.s_data;
      for (int k = 1; k < TAPS; k++) dly[k] <= dly[k-1];
    end
  end

  // Coefficient banks: writes land in shadow; active is refreshed only on accept, merging a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_ok) shadow[bus.coef_addr] <= bus.coef_wdata;
      if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          active[k] <= (wr_ok && (bus.coef_addr == AW'(k))) ? bus.coef_wdata : shadow[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: vector table, directed corner sequences, random traffic.
// A transaction-level model (sample history x coefficient snapshot) predicts every result.
// Honours FIR_SCHED_SAT_EN for the expected conversion.
module tb_fir_mac_scheduler;
  localparam int TAPS   = 4;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int AW     = $clog2(TAPS);

  typedef struct {
    int x;
    int y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_scheduler_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

  fir_mac_scheduler #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  longint shadow_m [TAPS];
  longint hist_m   [TAPS];
  longint exp_q    [$];
  int     acc_edges[$];
  int     last_acc_edge = 0;
  int     hs_count      = 0;
  bit     prev_mv       = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint conv_ref(input longint s);
`ifdef FIR_SCHED_SAT_EN
    longint hi;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    if (s > hi) return hi;
    if (s < -hi - 1) return -hi - 1;
    return s;
`else
    logic signed [OUT_W-1:0] w;
    w = s[OUT_W-1:0];
    return longint'(w);
`endif
  endfunction

  // Looks at what the coming rising edge will do and updates the model accordingly.
  task automatic monitor_step();
    longint sum;
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_m[k] = 0;
        hist_m[k]   = 0;
      end
      exp_q.delete();
      prev_mv = 1'b0;
    end else begin
      if (bus.m_valid && !prev_mv) check("latency", cyc - last_acc_edge, TAPS);
      if (bus.coef_we && (bus.coef_addr < TAPS)) shadow_m[bus.coef_addr] = bus.coef_wdata;
      if (bus.s_valid && bus.s_ready) begin
        for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = bus.s_data;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += hist_m[k] * shadow_m[k];
        exp_q.push_back(conv_ref(sum));
        last_acc_edge = cyc + 1;
        acc_edges.push_back(cyc + 1);
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check("unexpected_output", 0, 1);
        else check("model_data", bus.m_data, exp_q.pop_front());
      end
      prev_mv = bus.m_valid;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic write_coef(input int addr, input int val);
    @(posedge clk); #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = COEF_W'(val);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  task automatic send(input int x);
    bit ok;
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = DATA_W'(x);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output logic signed [OUT_W-1:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        ok = 1'b1;
        d  = bus.m_data;
        break;
      end
    end
    if (!ok) check("output_timeout", 0, 1);
  endtask

  vec_t step_tab[6];
  logic signed [OUT_W-1:0] d;
  int hs0;
  int mv_seen;

  initial begin
    step_tab[0] = '{9, 9};
    step_tab[1] = '{9, 18};
    step_tab[2] = '{9, 0};
    step_tab[3] = '{9, 45};
    step_tab[4] = '{9, 45};
    step_tab[5] = '{9, 45};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.m_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_busy",    bus.busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", bus.s_ready, 1);

    // Step response from a cleared delay line.
    load_coefs(1, 1, -2, 5);
    acc_edges.delete();
    for (int i = 0; i < 6; i++) begin
      send(step_tab[i].x);
      wait_out(d);
      check($sformatf("step%0d", i), d, step_tab[i].y);
    end
    for (int i = 1; i < 6 && i < acc_edges.size(); i++)
      check($sformatf("accept_gap%0d", i), acc_edges[i] - acc_edges[i-1], TAPS + 2);

    // Backpressure: result held while m_ready is low.
    @(posedge clk); #1; bus.m_ready = 1'b0;
    send(9);
    wait_out(d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", bus.m_valid, 1);
      check("bp_m_data",  bus.m_data, 45);
      check("bp_s_ready", bus.s_ready, 0);
    end
    hs0 = hs_count;
    @(posedge clk); #1; bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", bus.m_valid, 0);
    check("bp_one_handshake", hs_count - hs0, 1);

    // Coefficient write during MAC affects only the following output.
    send(9);
    write_coef(2, 2);
    wait_out(d);
    check("busy_write_inflight", d, 45);
    send(9);
    wait_out(d);
    check("busy_write_next", d, 81);

    // Overflow: four -128 samples against 127 coefficients.
    load_coefs(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) begin
      send(-128);
      wait_out(d);
    end
`ifdef FIR_SCHED_SAT_EN
    check("overflow", d, -32768);
`else
    check("overflow", d, 512);
`endif

    // Reset during MAC discards the computation and clears the delay line.
    send(9);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", bus.s_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    mv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_valid) mv_seen++;
    end
    check("midrst_no_output", mv_seen, 0);
    check("midrst_idle_busy", bus.busy, 0);
    load_coefs(1, 1, -2, 5);
    send(9);
    wait_out(d);
    check("midrst_first_out", d, 9);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.s_valid    = ($urandom_range(0, 2) != 0);
      bus.s_data     = DATA_W'($urandom);
      bus.m_ready    = ($urandom_range(0, 3) != 0);
      bus.coef_we    = ($urandom_range(0, 5) == 0);
      bus.coef_addr  = AW'($urandom);
      bus.coef_wdata = COEF_W'($urandom);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.coef_we = 1'b0; bus.m_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.m_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
